// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default baud divider.
// Used by both the TX streamer and the RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses bit_end on the last.
// Synchronous clear holds it at zero; shared with the RX sampler.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = ~clr & (cnt_q == LAST);
    cnt_d   = cnt_q + 1'b1;
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_streamer.sv
// FWFT FIFO to UART TX serializer, 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit before the stop bit(s).
module uart_tx_streamer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_streamer: illegal parameter");
  end

  uart_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  pop, baud_clr, bit_end;
  logic                  last_bit, last_stop;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign baud_clr = (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  // Gated by rst_n so no pop can be requested while in reset
  assign pop        = rst_n & enable & ~fifo_empty & (state_q == IDLE);
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign last_stop  = (bit_cnt_q == LAST_STOP);
  assign fifo_rd_en = pop;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign tx_done    = (state_q == STOP) & bit_end & last_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (pop) state_d = START;
      START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && last_bit) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && last_bit) state_d = STOP;
`endif
      STOP:   if (bit_end && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d   = fifo_dout;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d     = (^fifo_dout) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) tx_d = shreg_q[0];
      end
      DATA: begin
        if (bit_end && last_bit) begin
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          tx_d      = par_q;
`else
          tx_d      = 1'b1;
`endif
        end else if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_d      = shreg_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) tx_d = 1'b1;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          bit_cnt_d = last_stop ? '0 : bit_cnt_q + 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Bench for uart_tx_streamer: FIFO model, scoreboard and UART line monitor.
// Parity checks are active when UART_TX_PARITY_EN is defined.
module tb_uart_tx_streamer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, tx, busy, tx_done;

  int nvec = 0, nfail = 0;
  int cyc = 0, pops = 0, pop_cyc = 0, dones = 0;
  int p0, d0, k = 0, errs = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int start_q[$];
  bit inframe = 1'b0;
  logic [7:0] cur = 8'h00, rxb = 8'h00;
  logic [NB-1:0] fb = '1;
  logic rd, par_seen = 1'b0;
  logic low_seen, rd_seen, busy_seen;

  uart_tx_streamer #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task fifo_upd();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_upd();
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || fifo_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < maxc), 1);
  endtask

  task automatic wait_pop(input int maxc);
    int n = 0;
    int p = pops;
    while (pops == p && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("pop_timeout", (n < maxc), 1);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    int d = dones;
    while (dones == d && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", (n < maxc), 1);
  endtask

  // FIFO pops after the DUT has sampled fifo_dout on the pop edge
  always @(posedge clk) begin
    rd = fifo_rd_en;
    cyc++;
    if (rd) begin
      pops++;
      pop_cyc = cyc;
      #1;
      if (fifo_q.size() > 0) exp_q.push_back(fifo_q.pop_front());
      fifo_upd();
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      if (inframe && exp_q.size() > 0) void'(exp_q.pop_front());
      inframe = 1'b0;
    end else begin
      if (tx_done) begin
        dones++;
        chk("done_ofs", cyc + 1 - pop_cyc, FL);
      end
      if (!inframe && tx == 1'b0) begin
        inframe = 1'b1;
        k = 0;
        errs = 0;
        rxb = 8'h00;
        start_q.push_back(cyc);
        chk("start_has_exp", (exp_q.size() > 0), 1);
        cur = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, ^cur, cur, 1'b0};
`else
        fb = {1'b1, cur, 1'b0};
`endif
      end
      if (inframe) begin
        if (tx !== fb[k/CPB]) errs++;
        if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
          rxb[k/CPB-1] = tx;
        if (k == 9 * CPB + CPB / 2) par_seen = tx;
        if (k == FL - 1) begin
          chk("rx_byte", rxb, cur);
          chk("frame_bits", errs, 0);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          inframe = 1'b0;
        end
        k++;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    fifo_upd();
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_rd", fifo_rd_en, 0);
    rst_n = 1'b1;

    low_seen = 0; rd_seen = 0; busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx) low_seen = 1;
      if (fifo_rd_en) rd_seen = 1;
      if (busy) busy_seen = 1;
    end
    chk("idle_tx_low", low_seen, 0);
    chk("idle_rd", rd_seen, 0);
    chk("idle_busy", busy_seen, 0);

    p0 = pops; d0 = dones;
    push(8'hA5);
    wait_idle(200);
    chk("a5_pops", pops - p0, 1);
    chk("a5_dones", dones - d0, 1);

    p0 = pops;
    start_q.delete();
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_idle(400);
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("b2b_gap1", start_q[1] - start_q[0], FL + 1);
      chk("b2b_gap2", start_q[2] - start_q[1], FL + 1);
    end

    push(8'h55); push(8'h81);
    wait_pop(20);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    p0 = pops;
    wait_done(100);
    repeat (20) @(negedge clk);
    chk("en_no_pop", pops - p0, 0);
    chk("en_busy", busy, 0);
    enable = 1'b1;
    #1;
    chk("en_resume_rd", fifo_rd_en, 1);
    wait_idle(200);
    chk("en_pops", pops - p0, 1);

    p0 = pops;
    push(8'hC3); push(8'h5A);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_pop(20);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd", fifo_rd_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(200);
    chk("arst_pops", pops - p0, 2);

`ifdef UART_TX_PARITY_EN
    d0 = dones;
    push(8'h07);
    wait_idle(200);
    chk("par_07", par_seen, 1);
    chk("par_dones", dones - d0, 1);
`endif

    chk("exp_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
